// File: rtl/game_sprite_update_scheduler.sv
// game_sprite_update_scheduler
// Once every (frame_div+1) frames, walks the sprite list in index order,
// handshakes one update with each enabled sprite, then pulses
// collision_check so collision logic sees a consistent post-update snapshot.
// Every output is decoded from registered state; there is no combinational
// path from any input to any output.
module game_sprite_update_scheduler #(
    parameter int N_SPRITES   = 2,
    parameter int FRAME_DIV_W = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic [FRAME_DIV_W-1:0] frame_div,
    input  logic [N_SPRITES-1:0]   sprite_enable,
    input  logic [N_SPRITES-1:0]   update_ack,
    input  logic                   clear_errors,
    output logic [N_SPRITES-1:0]   update_req,
    output logic                   collision_check,
    output logic                   busy,
    output logic                   overrun,
    output logic                   ack_timeout
);

    // idx runs 0..N_SPRITES inclusive; the extra value marks "all sprites visited".
    localparam int IDX_W = $clog2(N_SPRITES + 1);
    // Wide enough to hold ACK_TIMEOUT-1 even when ACK_TIMEOUT is 1.
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEL   = 2'd1,
        REQ   = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t                 state, state_next;
    logic [IDX_W-1:0]       idx, idx_next;
    logic [N_SPRITES-1:0]   en_mask, en_mask_next;
    logic [FRAME_DIV_W-1:0] frame_cnt, frame_cnt_next;
    logic [TMR_W-1:0]       timer, timer_next;
    logic                   overrun_next;
    logic                   ack_timeout_next;

    // Zero-extended copies so idx == N_SPRITES can index them safely.
    logic [N_SPRITES:0]     en_ext;
    logic [N_SPRITES:0]     ack_ext;

    assign en_ext  = {1'b0, en_mask};
    assign ack_ext = {1'b0, update_ack};

    // Next-state, datapath and sticky-flag logic.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_next       = state;
        idx_next         = idx;
        en_mask_next     = en_mask;
        frame_cnt_next   = frame_cnt;
        timer_next       = timer;
        overrun_next     = overrun;
        ack_timeout_next = ack_timeout;

        if (clear_errors) begin
            overrun_next     = 1'b0;
            ack_timeout_next = 1'b0;
        end

        case (state)
            IDLE: begin
                if (frame_start) begin
                    // >= also catches frame_div lowered below the current count.
                    if (frame_cnt >= frame_div) begin
                        frame_cnt_next = '0;
                        en_mask_next   = sprite_enable;
                        idx_next       = '0;
                        state_next     = SEL;
                    end else begin
                        frame_cnt_next = frame_cnt + FRAME_DIV_W'(1);
                    end
                end
            end
            SEL: begin
                if (idx == IDX_W'(N_SPRITES)) begin
                    state_next = CHECK;
                end else if (en_ext[idx]) begin
                    timer_next = '0;
                    state_next = REQ;
                end else begin
                    idx_next = idx + IDX_W'(1);
                end
            end
            REQ: begin
                // Acks on other indices are deliberately ignored.
                if (ack_ext[idx]) begin
                    idx_next   = idx + IDX_W'(1);
                    state_next = SEL;
                end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
                    ack_timeout_next = 1'b1;
                    idx_next         = idx + IDX_W'(1);
                    state_next       = SEL;
                end else begin
                    timer_next = timer + TMR_W'(1);
                end
            end
            CHECK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A frame arriving mid-pass is dropped and flagged; set beats clear.
        if (frame_start && (state != IDLE)) begin
            overrun_next = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            en_mask     <= '0;
            frame_cnt   <= '0;
            timer       <= '0;
            overrun     <= 1'b0;
            ack_timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state       <= state_next;
            idx         <= idx_next;
            en_mask     <= en_mask_next;
            frame_cnt   <= frame_cnt_next;
            timer       <= timer_next;
            overrun     <= overrun_next;
            ack_timeout <= ack_timeout_next;
        end
    end

    // One-hot request decoded from the registered state and index.
    always_comb begin
        update_req = '0;
        for (int i = 0; i < N_SPRITES; i++) begin
            update_req[i] = (state == REQ) && (idx == IDX_W'(i));
        end
    end

    assign busy            = (state != IDLE);
    assign collision_check = (state == CHECK);

endmodule
